// File: rtl/adaptive_quantizer_if.sv
// Word-addressed read/write register bus. The master drives clk, resetn,
// baseaddr and the request fields. The slave returns rd_data one bus clock
// after rd_en.
interface rwbus_interface;
   logic        clk;
   logic        resetn;
   logic [31:0] baseaddr;
   logic [31:0] addr;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [31:0] rd_data;

   modport slave (
      input  clk, resetn, baseaddr, addr, wr_en, wr_data, rd_en,
      output rd_data
   );

   modport master (
      output clk, resetn, baseaddr, addr, wr_en, wr_data, rd_en,
      input  rd_data
   );
endinterface

// File: rtl/adaptive_quantizer.sv
// Adaptive requantizer: dat_out = sat(dat_in >>> shift).
// The shift adapts once per window of accepted samples, based on how many
// output samples hit the max or min code. Configuration lives on the bus
// clock and crosses to clk as one atomic word over a toggle handshake.
// Status crosses back to the bus clock over a second toggle handshake.
module adaptive_quantizer #(
   parameter logic [31:0] ID        = 32'h12345678,
   parameter int          N_DIG_IN  = 13,
   parameter int          N_DIG_OUT = 3
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic signed [N_DIG_IN-1:0]  dat_in,
   input  logic                        we,
   output logic signed [N_DIG_OUT-1:0] dat_out,
   output logic                        valid,
   rwbus_interface.slave               bus
);

   localparam int Q_MAX_I     = 2**(N_DIG_OUT-1) - 1;
   localparam int Q_MIN_I     = -(2**(N_DIG_OUT-1));
   localparam int SHIFT_MAX_I = N_DIG_IN - N_DIG_OUT;
   localparam logic signed [N_DIG_IN-1:0] Q_MAX = Q_MAX_I[N_DIG_IN-1:0];
   localparam logic signed [N_DIG_IN-1:0] Q_MIN = Q_MIN_I[N_DIG_IN-1:0];
   localparam logic [4:0] SHIFT_MAX = SHIFT_MAX_I[4:0];

   typedef struct packed {
      logic        adapt_en;
      logic [4:0]  man_shift;
      logic [4:0]  win_log2;
      logic [15:0] lo_cnt;
      logic [15:0] hi_cnt;
   } cfg_t;

   localparam cfg_t CFG_RST = '{adapt_en: 1'b1, man_shift: 5'd0, win_log2: 5'd10,
                                lo_cnt: 16'd32, hi_cnt: 16'd128};

   // ---------------- clk domain ----------------
   cfg_t        cfg, cfg_staged;
   logic [4:0]  shift;
   logic [20:0] win_cnt, sat_cnt;
   logic [15:0] sat_last;
   logic [1:0]  cfg_req_sync;
   logic        cfg_req_d;
   logic [31:0] stat_hold;
   logic        stat_req;
   logic [1:0]  stat_ack_sync;

   // ---------------- bus domain ----------------
   cfg_t        bus_cfg, cfg_hold;
   logic        cfg_req;
   logic [1:0]  cfg_ack_sync;
   logic [1:0]  stat_req_sync;
   logic        stat_req_d;
   logic [31:0] stat_bus;
   logic        bus_rst_n;

   // ---------------- datapath combinational terms ----------------
   logic signed [N_DIG_IN-1:0] shifted, q;
   logic        is_sat, win_end, apply;
   logic [4:0]  wl, shift_adj, man_clamped;
   logic [20:0] win_len_m1, sat_total;
   logic [31:0] stat_live;

   // Quantize the current sample and work out the window-end decision.
   // NOTE: every output of an always_comb block gets a value on every path,
   // otherwise synthesis infers a latch.
   always_comb begin
      shifted = dat_in >>> shift;
      q       = shifted;
      if (shifted > Q_MAX)      q = Q_MAX;
      else if (shifted < Q_MIN) q = Q_MIN;
      is_sat  = (q == Q_MAX) || (q == Q_MIN);

      wl = cfg.win_log2;
      if (wl < 5'd4)       wl = 5'd4;
      else if (wl > 5'd20) wl = 5'd20;
      win_len_m1 = (21'd1 << wl) - 21'd1;

      sat_total = sat_cnt + {20'd0, is_sat};
      win_end   = we && (win_cnt == win_len_m1);
      // A new configuration only takes effect between windows.
      apply     = win_end || ((win_cnt == 21'd0) && !we);

      shift_adj = shift;
      if (sat_total > {5'd0, cfg.hi_cnt}) begin
         if (shift != SHIFT_MAX) shift_adj = shift + 5'd1;
      end else if (sat_total < {5'd0, cfg.lo_cnt}) begin
         if (shift != 5'd0) shift_adj = shift - 5'd1;
      end

      man_clamped = (cfg_staged.man_shift > SHIFT_MAX) ? SHIFT_MAX : cfg_staged.man_shift;
      stat_live   = {sat_last, 11'd0, shift};
   end

   // Sample path, window counters and shift adaptation.
   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples the values from before this edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dat_out  <= '0;
         valid    <= 1'b0;
         shift    <= 5'd0;
         win_cnt  <= '0;
         sat_cnt  <= '0;
         sat_last <= '0;
         cfg      <= CFG_RST;
      end else begin
         valid <= we;
         if (we) begin
            dat_out <= q[N_DIG_OUT-1:0];
            if (win_end) begin
               win_cnt  <= '0;
               sat_cnt  <= '0;
               sat_last <= (sat_total > 21'h00FFFF) ? 16'hFFFF : sat_total[15:0];
            end else begin
               win_cnt <= win_cnt + 21'd1;
               sat_cnt <= sat_total;
            end
         end
         if (win_end && cfg.adapt_en) shift <= shift_adj;
         if (apply) begin
            cfg <= cfg_staged;
            if (!cfg_staged.adapt_en) shift <= man_clamped;
         end
      end
   end

   // Receive config words from the bus side and send status words back.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cfg_req_sync  <= '0;
         cfg_req_d     <= 1'b0;
         cfg_staged    <= CFG_RST;
         stat_ack_sync <= '0;
         stat_hold     <= '0;
         stat_req      <= 1'b0;
      end else begin
         cfg_req_sync <= {cfg_req_sync[0], cfg_req};
         cfg_req_d    <= cfg_req_sync[1];
         // cfg_hold is stable while a request is in flight.
         if (cfg_req_sync[1] != cfg_req_d) cfg_staged <= cfg_hold;

         stat_ack_sync <= {stat_ack_sync[0], stat_req_d};
         if ((stat_ack_sync[1] == stat_req) && (stat_hold != stat_live)) begin
            stat_hold <= stat_live;
            stat_req  <= ~stat_req;
         end
      end
   end

   // The sample-side reset also clears the bus-side registers.
   assign bus_rst_n = resetn & bus.resetn;

   // Register file, config launch and status capture on the bus clock.
   always_ff @(posedge bus.clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         bus_cfg       <= CFG_RST;
         cfg_hold      <= CFG_RST;
         cfg_req       <= 1'b0;
         cfg_ack_sync  <= '0;
         stat_req_sync <= '0;
         stat_req_d    <= 1'b0;
         stat_bus      <= '0;
         bus.rd_data   <= '0;
      end else begin
         if (bus.wr_en) begin
            case (bus.addr - bus.baseaddr)
               32'd1: begin
                  bus_cfg.adapt_en  <= bus.wr_data[0];
                  bus_cfg.man_shift <= bus.wr_data[12:8];
               end
               32'd2: bus_cfg.win_log2 <= bus.wr_data[4:0];
               32'd3: begin
                  bus_cfg.lo_cnt <= bus.wr_data[15:0];
                  bus_cfg.hi_cnt <= bus.wr_data[31:16];
               end
               default: ;
            endcase
         end

         if (bus.rd_en) begin
            case (bus.addr - bus.baseaddr)
               32'd0:   bus.rd_data <= ID;
               32'd1:   bus.rd_data <= {19'd0, bus_cfg.man_shift, 7'd0, bus_cfg.adapt_en};
               32'd2:   bus.rd_data <= {27'd0, bus_cfg.win_log2};
               32'd3:   bus.rd_data <= {bus_cfg.hi_cnt, bus_cfg.lo_cnt};
               32'd4:   bus.rd_data <= stat_bus;
               default: bus.rd_data <= '0;
            endcase
         end

         // Launch a new config word whenever the handshake is idle and the
         // registers differ from the last word sent.
         cfg_ack_sync <= {cfg_ack_sync[0], cfg_req_d};
         if ((cfg_ack_sync[1] == cfg_req) && (cfg_hold != bus_cfg)) begin
            cfg_hold <= bus_cfg;
            cfg_req  <= ~cfg_req;
         end

         stat_req_sync <= {stat_req_sync[0], stat_req};
         stat_req_d    <= stat_req_sync[1];
         if (stat_req_sync[1] != stat_req_d) stat_bus <= stat_hold;
      end
   end

endmodule

// File: tb/tb_adaptive_quantizer.sv
// Directed bench for adaptive_quantizer: register map, manual quantization,
// adaptive shift stepping, random full-scale input, gated strobes and
// mid-stream reset.
module tb_adaptive_quantizer;

   localparam logic [31:0] BASE = 32'h0000_0100;

   logic              clk = 1'b0;
   logic              resetn;
   logic signed [12:0] dat_in;
   logic              we;
   logic signed [2:0] dat_out;
   logic              valid;

   int n_checks = 0;
   int n_pass   = 0;

   rwbus_interface bus_if ();

   adaptive_quantizer dut (
      .clk     (clk),
      .resetn  (resetn),
      .dat_in  (dat_in),
      .we      (we),
      .dat_out (dat_out),
      .valid   (valid),
      .bus     (bus_if)
   );

   always #5 clk = ~clk;

   initial bus_if.clk = 1'b0;
   always #7 bus_if.clk = ~bus_if.clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input int off, input logic [31:0] data);
      @(negedge bus_if.clk);
      bus_if.addr    = BASE + off;
      bus_if.wr_data = data;
      bus_if.wr_en   = 1'b1;
      @(negedge bus_if.clk);
      bus_if.wr_en   = 1'b0;
   endtask

   task automatic bus_read(input int off, output logic [31:0] data);
      @(negedge bus_if.clk);
      bus_if.addr  = BASE + off;
      bus_if.rd_en = 1'b1;
      @(negedge bus_if.clk);
      bus_if.rd_en = 1'b0;
      data = bus_if.rd_data;
   endtask

   // Read STAT after letting it settle across the clock boundary.
   task automatic check_stat(input string tag, input int exp_shift, input int exp_sat);
      logic [31:0] r;
      wait_clk(12);
      bus_read(4, r);
      check({tag, "_shift"}, int'(r[4:0]), exp_shift);
      check({tag, "_sat"}, int'(r[31:16]), exp_sat);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      resetn = 1'b0;
      we     = 1'b0;
      wait_clk(3);
      resetn = 1'b1;
      wait_clk(3);
   endtask

   function automatic int qmodel(input int x, input int s);
      int y;
      y = x >>> s;
      if (y > 3)  y = 3;
      if (y < -4) y = -4;
      return y;
   endfunction

   function automatic int next_shift(input int s, input int satc, input int lo, input int hi);
      if (satc > hi) return (s < 10) ? s + 1 : s;
      if (satc < lo) return (s > 0) ? s - 1 : s;
      return s;
   endfunction

   function automatic int sdat();
      return int'(dat_out);
   endfunction

   // Stream n back-to-back samples at a known shift.
   // kind 0 sends a constant value, kind 1 sends full-scale random samples.
   // Every output is checked and the number of saturated outputs is returned.
   task automatic run_samples(input int n, input int kind, input int value,
                              input int s, output int satc);
      int x, exp_q;
      logic [31:0] xv;
      satc  = 0;
      exp_q = 0;
      for (int i = 0; i < n; i++) begin
         x = (kind == 1) ? int'($urandom_range(0, 8191)) - 4096 : value;
         xv = x;
         @(negedge clk);
         if (i > 0) begin
            check("stream_dat", sdat(), exp_q);
            check("stream_valid", int'(valid), 1);
         end
         dat_in = xv[12:0];
         we     = 1'b1;
         exp_q  = qmodel(x, s);
         if (exp_q == 3 || exp_q == -4) satc++;
      end
      @(negedge clk);
      check("stream_dat_last", sdat(), exp_q);
      check("stream_valid_last", int'(valid), 1);
      we = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      int s, satc, got_id, exp_v;
      int man_in  [4] = '{100, -40, -100, 15};
      int man_exp [4] = '{3, -3, -4, 0};
      logic [31:0] xv;

      resetn         = 1'b0;
      we             = 1'b0;
      dat_in         = '0;
      bus_if.resetn  = 1'b0;
      bus_if.baseaddr = BASE;
      bus_if.addr    = '0;
      bus_if.wr_en   = 1'b0;
      bus_if.wr_data = '0;
      bus_if.rd_en   = 1'b0;

      #3;
      check("rst_dat_out", sdat(), 0);
      check("rst_valid", int'(valid), 0);
      #30;
      resetn        = 1'b1;
      bus_if.resetn = 1'b1;

      // Poll the ID register for at most 10 bus cycles.
      got_id = 0;
      for (int i = 0; i < 5 && got_id == 0; i++) begin
         bus_read(0, r);
         if (r == 32'h12345678) got_id = 1;
      end
      check("id_poll", int'(r), 32'h12345678);

      bus_read(1, r);  check("rst_ctrl", int'(r), 1);
      bus_read(2, r);  check("rst_win", int'(r), 10);
      bus_read(3, r);  check("rst_thr", int'(r), 32'h0080_0020);
      bus_read(4, r);  check("rst_stat", int'(r), 0);
      bus_read(6, r);  check("unmapped", int'(r), 0);
      bus_write(0, 32'hDEAD_BEEF);
      bus_read(0, r);  check("id_ro", int'(r), 32'h12345678);

      // Full-scale random at defaults: shift ramps up to 10 and holds there.
      s = 0;
      for (int w = 0; w < 12; w++) begin
         run_samples(1024, 1, 0, s, satc);
         s = next_shift(s, satc, 32, 128);
         check_stat("rand_win", s, satc);
      end
      // Constant zero never saturates, so the shift walks back down to 0.
      for (int w = 0; w < 11; w++) begin
         run_samples(1024, 0, 0, s, satc);
         s = next_shift(s, satc, 32, 128);
         check_stat("zero_win", s, satc);
      end

      // Manual mode, MAN_SHIFT = 4.
      apply_reset();
      bus_write(1, 32'h0000_0400);
      wait_clk(20);
      for (int i = 0; i < 4; i++) begin
         xv = man_in[i];
         @(negedge clk);
         dat_in = xv[12:0];
         we     = 1'b1;
         @(negedge clk);
         we = 1'b0;
         check("man_dat", sdat(), man_exp[i]);
         check("man_valid", int'(valid), 1);
         @(negedge clk);
         check("man_valid_drop", int'(valid), 0);
         check("man_hold", sdat(), man_exp[i]);
      end
      check_stat("man_stat", 4, 0);

      // Adaptive mode, 16-sample windows, LO = 2, HI = 8, constant 1000.
      apply_reset();
      bus_write(2, 32'd4);
      bus_write(3, {16'd8, 16'd2});
      wait_clk(20);
      s = 0;
      for (int w = 0; w < 11; w++) begin
         run_samples(16, 0, 1000, s, satc);
         s = next_shift(s, satc, 2, 8);
         check_stat("adapt_win", s, satc);
      end

      // Strobe toggling at 50%: only accepted samples advance the window.
      apply_reset();
      bus_write(2, 32'd4);
      bus_write(3, {16'd8, 16'd2});
      wait_clk(20);
      we = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (i > 0) check("tog_valid", int'(valid), (i % 2 == 1) ? 1 : 0);
         dat_in = 13'sd1000;
         we     = (i % 2 == 0);
         if (i == 29) begin
            @(negedge clk);
            we = 1'b0;
            check_stat("tog_15", 0, 0);
         end
      end
      @(negedge clk);
      we = 1'b0;
      check_stat("tog_16", 1, 16);

      // Reset mid-window: state clears at once and the next window starts from 0.
      run_samples(4, 0, 1000, 1, satc);
      @(negedge clk);
      dat_in = 13'sd1000;
      we     = 1'b1;
      @(negedge clk);
      check("pre_rst_valid", int'(valid), 1);
      resetn = 1'b0;
      #1;
      check("mid_rst_dat", sdat(), 0);
      check("mid_rst_valid", int'(valid), 0);
      we = 1'b0;
      wait_clk(3);
      resetn = 1'b1;
      wait_clk(3);
      check_stat("mid_rst_stat", 0, 0);
      bus_read(1, r);  check("mid_rst_ctrl", int'(r), 1);
      bus_read(2, r);  check("mid_rst_win", int'(r), 10);
      bus_read(3, r);  check("mid_rst_thr", int'(r), 32'h0080_0020);
      bus_write(2, 32'd4);
      bus_write(3, {16'd8, 16'd2});
      wait_clk(20);
      run_samples(15, 0, 1000, 0, satc);
      check_stat("restart_15", 0, 0);
      run_samples(1, 0, 1000, 0, satc);
      exp_v = 16;
      check_stat("restart_16", 1, exp_v);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
